// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the AES key schedule.
package aes_pkg;

    typedef enum logic [1:0] {
        MODE_128  = 2'd0,
        MODE_192  = 2'd1,
        MODE_256  = 2'd2,
        MODE_RSVD = 2'd3
    } key_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN,
        ST_SUB,
        ST_WAIT
    } ks_state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic logic [3:0] nk_of(input key_mode_e m);
        case (m)
            MODE_192: return 4'd6;
            MODE_256: return 4'd8;
            default:  return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_mode_e m);
        case (m)
            MODE_192: return 4'd12;
            MODE_256: return 4'd14;
            default:  return 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// SubBytes S-box: multiplicative inverse in GF(2^8) (a^254) followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);

    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

    // Square-and-multiply chain for a^254; a=0 maps to 0 as required.
    assign x2   = gf_mul(a, a);
    assign x3   = gf_mul(x2, a);
    assign x6   = gf_mul(x3, x3);
    assign x7   = gf_mul(x6, a);
    assign x14  = gf_mul(x7, x7);
    assign x15  = gf_mul(x14, a);
    assign x30  = gf_mul(x15, x15);
    assign x31  = gf_mul(x30, a);
    assign x62  = gf_mul(x31, x31);
    assign x63  = gf_mul(x62, a);
    assign x126 = gf_mul(x63, x63);
    assign x127 = gf_mul(x126, a);
    assign inv  = gf_mul(x127, x127);

    assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_sub_word.sv
// SubWord slice: substitutes SBOX_LANES bytes of a word per step; unselected bytes read as zero.
module aes_sub_word #(
    parameter int SBOX_LANES = 4
) (
    input  logic [31:0] word_in,
    input  logic [1:0]  step,
    output logic [31:0] word_out
);

    logic [1:0] lane_pos [SBOX_LANES];
    logic [7:0] lane_in  [SBOX_LANES];
    logic [7:0] lane_out [SBOX_LANES];

    // Byte position 0 is the most significant byte of the word.
    always_comb begin
        for (int j = 0; j < SBOX_LANES; j++) begin
            lane_pos[j] = 2'(int'(step) * SBOX_LANES + j);
            lane_in[j]  = word_in[8*(3-int'(lane_pos[j])) +: 8];
        end
    end

    for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
        aes_sbox u_sbox (
            .a (lane_in[g]),
            .s (lane_out[g])
        );
    end

    always_comb begin
        word_out = '0;
        for (int j = 0; j < SBOX_LANES; j++) begin
            word_out[8*(3-int'(lane_pos[j])) +: 8] = lane_out[j];
        end
    end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key schedule: one expanded word per commit, one round key per handshake.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int SBOX_LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_mode,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_o,
    output logic [3:0]   rk_idx,
    output logic         rk_last,
    output logic         mode_err
);

    localparam logic [1:0] LAST_STEP = 2'(4 / SBOX_LANES - 1);

    ks_state_e    state, state_d;
    key_mode_e    mode_q;
    logic [255:0] key_q;
    logic [31:0]  win [8];
    logic [5:0]   widx;
    logic [3:0]   kpos;
    logic [7:0]   rcon;
    logic [31:0]  temp, sub_acc, hold_w, sub_out;
    logic [1:0]   step;
    logic         rcon_word;
    logic [31:0]  c0, c1, c2;

    logic [3:0]   nk, nr;
    logic [5:0]   total;
    logic [31:0]  w_prev, w_nk, key_word, new_w, commit_w;
    logic         word_rdy, commit, hold_load, start_sub, rot_sub, finish;
    logic         accept, start_ok, group_end;

    assign nk        = nk_of(mode_q);
    assign nr        = nr_of(mode_q);
    assign total     = {nr, 2'b00} + 6'd4;
    assign w_prev    = win[0];
    assign w_nk      = win[3'(nk - 4'd1)];
    assign key_word  = key_q[255 - 32*int'(widx[2:0]) -: 32];
    assign accept    = rk_valid && rk_ready;
    assign start_ok  = start && (key_mode != 2'd3);
    assign group_end = (widx[1:0] == 2'd3);

    aes_sub_word #(.SBOX_LANES(SBOX_LANES)) u_sub_word (
        .word_in  (temp),
        .step     (step),
        .word_out (sub_out)
    );

    always_comb begin
        state_d   = state;
        word_rdy  = 1'b0;
        new_w     = '0;
        commit    = 1'b0;
        commit_w  = '0;
        hold_load = 1'b0;
        start_sub = 1'b0;
        rot_sub   = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: if (start_ok) state_d = ST_GEN;
            ST_GEN: begin
                if (widx >= total) begin
                    if (accept && rk_last) begin
                        state_d = ST_IDLE;
                        finish  = 1'b1;
                    end
                end else if (widx < 6'(nk)) begin
                    new_w    = key_word;
                    word_rdy = 1'b1;
                end else if (kpos == 4'd0) begin
                    start_sub = 1'b1;
                    rot_sub   = 1'b1;
                    state_d   = ST_SUB;
                end else if (nk == 4'd8 && kpos == 4'd4) begin
                    start_sub = 1'b1;
                    state_d   = ST_SUB;
                end else begin
                    new_w    = w_nk ^ w_prev;
                    word_rdy = 1'b1;
                end
            end
            ST_SUB: begin
                if (step == LAST_STEP) begin
                    new_w    = w_nk ^ (sub_acc | sub_out) ^ (rcon_word ? {rcon, 24'h0} : 32'h0);
                    word_rdy = 1'b1;
                    state_d  = ST_GEN;
                end
            end
            ST_WAIT: begin
                if (rk_ready) begin
                    commit   = 1'b1;
                    commit_w = hold_w;
                    state_d  = ST_GEN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A group-completing word must not overwrite a round key still awaiting its consumer.
        if (word_rdy) begin
            if (group_end && rk_valid && !rk_ready) begin
                hold_load = 1'b1;
                state_d   = ST_WAIT;
            end else begin
                commit   = 1'b1;
                commit_w = new_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_128;
            busy      <= 1'b0;
            rk_valid  <= 1'b0;
            rk_last   <= 1'b0;
            mode_err  <= 1'b0;
            rk_o      <= '0;
            rk_idx    <= '0;
            widx      <= '0;
            kpos      <= '0;
            rcon      <= RCON_INIT;
            step      <= '0;
            rcon_word <= 1'b0;
            for (int k = 0; k < 8; k++) win[k] <= '0;
        end else begin
            state    <= state_d;
            mode_err <= (state == ST_IDLE) && start && (key_mode == 2'd3);
            if (state == ST_IDLE && start_ok) begin
                key_q  <= key_in;
                mode_q <= key_mode_e'(key_mode);
                busy   <= 1'b1;
                widx   <= '0;
                kpos   <= '0;
                rcon   <= RCON_INIT;
            end
            if (finish) busy <= 1'b0;

            if (start_sub) begin
                temp      <= rot_sub ? {w_prev[23:0], w_prev[31:24]} : w_prev;
                rcon_word <= rot_sub;
                step      <= '0;
                sub_acc   <= '0;
            end else if (state == ST_SUB) begin
                sub_acc <= sub_acc | sub_out;
                step    <= step + 2'd1;
            end
            if (state == ST_SUB && step == LAST_STEP && rcon_word) rcon <= xtime(rcon);
            if (hold_load) hold_w <= new_w;

            if (commit) begin
                win[0] <= commit_w;
                for (int k = 1; k < 8; k++) win[k] <= win[k-1];
                widx <= widx + 6'd1;
                kpos <= (kpos == nk - 4'd1) ? 4'd0 : kpos + 4'd1;
                case (widx[1:0])
                    2'd0:    c0 <= commit_w;
                    2'd1:    c1 <= commit_w;
                    2'd2:    c2 <= commit_w;
                    default: ;
                endcase
            end
            // Loading a new key takes priority over retiring the accepted one.
            if (commit && group_end) begin
                rk_o     <= {c0, c1, c2, commit_w};
                rk_valid <= 1'b1;
                rk_idx   <= widx[5:2];
                rk_last  <= (widx[5:2] == nr);
            end else if (accept) begin
                rk_valid <= 1'b0;
                rk_last  <= 1'b0;
            end
        end
    end

endmodule
